weight_stream_reader: RTL and testbench

- Read-side sequencer for a neuron weight ROM (W_Mem_* family: `ren`/`radd` in, `wout` registered one cycle later).
- On `start`, walks addresses 0..numWeight-1 and drives the ROM read port.
- Captures each returned word into a 2-entry output buffer and streams it to the MAC datapath over a valid/ready handshake, with full backpressure support.
- Sits between one weight memory and one neuron MAC unit.

---
 rtl/weight_stream_reader_if.sv | 29 ++
 rtl/weight_stream_reader.sv | 143 ++++++++++++++
 tb/tb_weight_stream_reader.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_stream_reader_if.sv
// Bundles the weight ROM read port and the weight stream handshake
// of the reader into one interface.
interface weight_stream_reader_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  // weight ROM read port
  logic          mem_ren;
  logic [AW-1:0] mem_radd;
  logic [DW-1:0] mem_wout;
  // weight stream towards the MAC datapath
  logic          w_valid;
  logic          w_ready;
  logic [DW-1:0] w_data;
  logic [AW-1:0] w_idx;
  logic          w_last;

  // reader side: drives the ROM address and the weight stream
  modport master (
    output mem_ren, mem_radd, w_valid, w_data, w_idx, w_last,
    input  mem_wout, w_ready
  );

  // ROM plus MAC side
  modport slave (
    input  mem_ren, mem_radd, w_valid, w_data, w_idx, w_last,
    output mem_wout, w_ready
  );
endinterface

// File: rtl/weight_stream_reader.sv
// Weight ROM read sequencer. On start it reads addresses 0..numWeight-1
// from a ROM with a one-cycle read latency. Each returned word goes into a
// 2-entry buffer, and the buffer feeds the MAC over valid/ready.
// A read is issued only when its word is certain to find a free slot, so
// backpressure of any length loses nothing and needs no extra storage.
module weight_stream_reader #(
  parameter int numWeight    = 30,
  parameter int addressWidth = $clog2(numWeight),
  parameter int dataWidth    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy,
  output logic done,
  weight_stream_reader_if.master bus
);

  localparam int AW = addressWidth;
  localparam int DW = dataWidth;
  localparam logic [AW-1:0] LAST = AW'(numWeight - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e                 state_q, state_d;
  logic [AW-1:0]          ptr_q, ptr_d;
  logic                   done_q, done_d;
  logic                   inflight_q;
  logic [AW-1:0]          infl_addr_q;
  logic [1:0]             cnt_q, cnt_d;
  logic                   wr_q, rd_q;
  logic [1:0][DW-1:0]     buf_data_q;
  logic [1:0][AW-1:0]     buf_idx_q;

  logic                   valid;
  logic                   pop;
  logic                   push;
  logic                   issue;
  logic                   head_last;
  logic [2:0]             occ;

  assign valid     = (cnt_q != 2'd0);
  assign pop       = valid & bus.w_ready;
  assign push      = inflight_q;
  assign head_last = (buf_idx_q[rd_q] == LAST);

  // Slots already claimed: words held in the buffer plus the word coming
  // back from the ROM this cycle. A pop in this cycle frees one slot.
  assign occ   = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign issue = (state_q == S_FETCH) && (occ < (3'd2 + {2'b00, pop}));

  // Next-state logic: pass sequencing, read pointer and the done pulse
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          ptr_d   = '0;
        end
      end
      S_FETCH: begin
        if (issue) begin
          // The pointer stops at the last address; there is no read past the ROM.
          if (ptr_q == LAST) state_d = S_DRAIN;
          else               ptr_d   = ptr_q + AW'(1);
        end
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer occupancy after this cycle's push and pop
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control registers: FSM state, read pointer and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
    end
  end

  // Track the outstanding ROM read and its address, which is needed to tag the returned word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q  <= 1'b0;
      infl_addr_q <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) infl_addr_q <= ptr_q;
    end
  end

  // Two-entry circular output buffer. Write and read pointers are 1 bit each.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data_q <= '0;
      buf_idx_q  <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      if (push) begin
        buf_data_q[wr_q] <= bus.mem_wout;
        buf_idx_q[wr_q]  <= infl_addr_q;
        wr_q             <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end

  assign bus.mem_ren  = issue;
  assign bus.mem_radd = ptr_q;
  assign bus.w_valid  = valid;
  assign bus.w_data   = buf_data_q[rd_q];
  assign bus.w_idx    = buf_idx_q[rd_q];
  assign bus.w_last   = valid & head_last;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;

endmodule

// File: tb/tb_weight_stream_reader.sv
// Scoreboard bench for weight_stream_reader. The stimulus queues the beats
// it expects, and a negedge monitor pops and compares each handshake.
// A second instance is built with numWeight=10.
module tb_weight_stream_reader;
  localparam int NW   = 30;
  localparam int AW   = $clog2(NW);
  localparam int DW   = 16;
  localparam int NW10 = 10;
  localparam int AW10 = $clog2(NW10);

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start10 = 1'b0;
  logic busy, done, busy10, done10;

  always #5 clk = ~clk;

  weight_stream_reader_if #(.AW(AW),   .DW(DW)) bus();
  weight_stream_reader_if #(.AW(AW10), .DW(DW)) bus10();

  weight_stream_reader #(.numWeight(NW), .addressWidth(AW), .dataWidth(DW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .bus(bus)
  );

  weight_stream_reader #(.numWeight(NW10), .addressWidth(AW10), .dataWidth(DW)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .start(start10), .busy(busy10), .done(done10), .bus(bus10)
  );

  // ROM models: mem[i] = 0x0100 + i, read data registered one cycle after ren
  always @(posedge clk) if (bus.mem_ren)   bus.mem_wout   <= 16'h0100 + 16'(bus.mem_radd);
  always @(posedge clk) if (bus10.mem_ren) bus10.mem_wout <= 16'h0100 + 16'(bus10.mem_radd);

  initial bus10.w_ready = 1'b1;

  // w_ready patterns: 0 = always 1, 1 = 1,0,0,1 repeating, 2 = always 0
  int rdy_mode = 0;
  int pat = 0;
  always @(posedge clk) begin
    #1;
    pat = pat + 1;
    case (rdy_mode)
      1:       bus.w_ready = ((pat % 4) == 0) || ((pat % 4) == 3);
      2:       bus.w_ready = 1'b0;
      default: bus.w_ready = 1'b1;
    endcase
  end

  int    nchk = 0;
  int    nerr = 0;
  int    beats = 0;
  int    rd_cnt = 0;
  int    exp10 = 0;
  beat_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_pass();
    for (int i = 0; i < NW; i++) begin
      beat_t b;
      b.idx  = AW'(i);
      b.data = 16'h0100 + 16'(i);
      b.last = (i == NW - 1);
      sb.push_back(b);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, inout int n);
    int k = 0;
    do begin
      @(negedge clk); n++; k++;
    end while (!done && k < budget);
    chk("done_seen", done, 1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    int k = 0;
    while (beats < target && k < budget) begin
      @(negedge clk); k++;
    end
    chk("beats_reached", beats >= target, 1);
  endtask

  // Monitor: occupancy model, scoreboard pops, stall stability, done timing
  int            cnt_m, infl_m, popi;
  logic          last_pop_p, stall_p;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_i;
  beat_t         e;
  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_m = 0; infl_m = 0; last_pop_p = 1'b0; stall_p = 1'b0;
    end else begin
      popi = (bus.w_valid && bus.w_ready) ? 1 : 0;
      chk("w_valid_model", bus.w_valid, cnt_m > 0);
      chk("done_after_last", done, last_pop_p);
      if (stall_p && bus.w_valid) begin
        chk("stall_data_hold", bus.w_data, hold_d);
        chk("stall_idx_hold", bus.w_idx, hold_i);
      end
      if (bus.mem_ren) begin
        rd_cnt++;
        chk("radd_range", bus.mem_radd < NW, 1);
      end
      if (cnt_m + infl_m - popi >= 2) chk("ren_when_full", bus.mem_ren, 0);
      if (popi == 1) begin
        if (sb.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL sb_underflow: got beat idx %0d expected none", bus.w_idx);
        end else begin
          e = sb.pop_front();
          chk("beat_idx", bus.w_idx, e.idx);
          chk("beat_data", bus.w_data, e.data);
          chk("beat_last", bus.w_last, e.last);
        end
        beats++;
      end
      last_pop_p = (popi == 1) && bus.w_last;
      stall_p    = bus.w_valid && !bus.w_ready;
      hold_d     = bus.w_data;
      hold_i     = bus.w_idx;
      cnt_m      = cnt_m + infl_m - popi;
      infl_m     = bus.mem_ren ? 1 : 0;
    end
  end

  // Monitor for the numWeight=10 instance
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus10.mem_ren) chk("radd10_range", bus10.mem_radd <= 4'd9, 1);
      if (bus10.w_valid && bus10.w_ready) begin
        chk("idx10", bus10.w_idx, exp10);
        chk("data10", bus10.w_data, 16'h0100 + exp10);
        chk("last10", bus10.w_last, exp10 == NW10 - 1);
        exp10++;
      end
    end
  end

  initial begin
    int n, base, k;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_w_valid", bus.w_valid, 0);
    chk("rst_mem_ren", bus.mem_ren, 0);
    chk("rst_w_data", bus.w_data, 0);
    chk("rst_w_idx", bus.w_idx, 0);
    chk("rst_w_last", bus.w_last, 0);
    @(negedge clk); rst_n = 1'b1;

    // full-rate pass: first valid 2 cycles after start, done at cycle 33
    rdy_mode = 0;
    push_pass();
    pulse_start();
    n = 0;
    repeat (3) begin
      @(negedge clk); n++;
      chk("first_valid_latency", bus.w_valid, n == 3);
    end
    wait_done(200, n);
    chk("done_cycle", n, 33);
    chk("sb_empty_t1", sb.size(), 0);

    // toggling backpressure 1,0,0,1
    rdy_mode = 1;
    push_pass();
    pulse_start();
    n = 0;
    wait_done(400, n);
    chk("sb_empty_t2", sb.size(), 0);

    // held backpressure: exactly two reads issued, head stays at index 0
    rdy_mode = 2;
    push_pass();
    @(negedge clk);
    rd_cnt = 0;
    pulse_start();
    repeat (10) @(negedge clk);
    chk("stall_reads", rd_cnt, 2);
    chk("stall_head_idx", bus.w_idx, 0);
    chk("stall_head_valid", bus.w_valid, 1);
    rdy_mode = 0;
    n = 0;
    wait_done(200, n);
    chk("sb_empty_t3", sb.size(), 0);

    // start while busy is ignored; start in the done cycle is accepted
    base = beats;
    push_pass();
    pulse_start();
    wait_beats(base + 5, 100);
    pulse_start();
    n = 0;
    wait_done(200, n);
    chk("beats_busy_start", beats - base, 30);
    chk("sb_empty_t4", sb.size(), 0);
    base = beats;
    push_pass();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    wait_done(200, n);
    chk("beats_done_start", beats - base, 30);
    chk("sb_empty_t4b", sb.size(), 0);

    // asynchronous reset mid-pass, then restart from index 0
    base = beats;
    push_pass();
    pulse_start();
    wait_beats(base + 12, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_w_valid", bus.w_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mem_ren", bus.mem_ren, 0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    push_pass();
    pulse_start();
    n = 0;
    wait_done(200, n);
    chk("sb_empty_t5", sb.size(), 0);

    // numWeight=10 instance
    exp10 = 0;
    @(posedge clk); #1 start10 = 1'b1;
    @(posedge clk); #1 start10 = 1'b0;
    k = 0;
    while (!done10 && k < 100) begin
      @(negedge clk); k++;
    end
    chk("done10_seen", done10, 1);
    chk("beats10", exp10, NW10);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
